// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with persistent N/Z/C/V flags and an
// iterative shift-add multiplier behind a valid/ready issue port.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic [3:0]       opcode_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             flags_clr_i,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic [3:0]       flags_o
);

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_NAND = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_ADD  = 4'd6;
  localparam logic [3:0] OP_SUB  = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SBC  = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_SAR  = 4'd12;
  localparam logic [3:0] OP_ROL  = 4'd13;
  localparam logic [3:0] OP_CMP  = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q, flags_d;
  logic                 valid_q, valid_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   ma_q, ma_d;
  logic [WIDTH-1:0]     mb_q, mb_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  logic [SHW-1:0]     s;
  logic [SHW:0]       rsh;
  logic [WIDTH-1:0]   bop;
  logic               cin;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     shl_w;
  logic [WIDTH:0]     shr_w;
  logic [WIDTH:0]     sar_w;
  logic [WIDTH-1:0]   rol;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c;
  logic               sc_v;
  logic [2*WIDTH-1:0] acc_nx;

  assign ready_o  = (state_q == S_IDLE);
  assign result_o = result_q;
  assign valid_o  = valid_q;
  assign flags_o  = flags_q;

  // Single-cycle datapath, evaluated on the live operands.
  always_comb begin
    s     = operand_b_i[SHW-1:0];
    rsh   = (SHW+1)'(WIDTH) - {1'b0, s};
    bop   = operand_b_i;
    cin   = 1'b0;
    unique case (opcode_i)
      OP_SUB, OP_CMP: begin bop = ~operand_b_i; cin = 1'b1; end
      OP_ADC:         cin = flags_q[1];
      OP_SBC:         begin bop = ~operand_b_i; cin = flags_q[1]; end
      default:        ;
    endcase
    sum   = {1'b0, operand_a_i} + {1'b0, bop}
          + {{WIDTH{1'b0}}, cin};
    shl_w = {1'b0, operand_a_i} << s;
    shr_w = {operand_a_i, 1'b0} >> s;
    sar_w = $unsigned($signed({operand_a_i, 1'b0}) >>> s);
    rol   = (operand_a_i << s) | (operand_a_i >> rsh);

    sc_res = '0;
    sc_c   = flags_q[1];
    sc_v   = 1'b0;
    unique case (opcode_i)
      OP_AND:  sc_res = operand_a_i & operand_b_i;
      OP_NAND: sc_res = ~(operand_a_i & operand_b_i);
      OP_OR:   sc_res = operand_a_i | operand_b_i;
      OP_NOR:  sc_res = ~(operand_a_i | operand_b_i);
      OP_XOR:  sc_res = operand_a_i ^ operand_b_i;
      OP_XNOR: sc_res = ~(operand_a_i ^ operand_b_i);
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (operand_a_i[WIDTH-1] == bop[WIDTH-1])
               & (sum[WIDTH-1] != operand_a_i[WIDTH-1]);
      end
      OP_SHL: begin
        sc_res = shl_w[WIDTH-1:0];
        if (s != '0) sc_c = shl_w[WIDTH];
      end
      OP_SHR: begin
        sc_res = shr_w[WIDTH:1];
        if (s != '0) sc_c = shr_w[0];
      end
      OP_SAR: begin
        sc_res = sar_w[WIDTH:1];
        if (s != '0) sc_c = sar_w[0];
      end
      OP_ROL: begin
        sc_res = rol;
        if (s != '0) sc_c = rol[0];
      end
      OP_MUL: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    valid_d  = 1'b0;
    acc_d    = acc_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    cnt_d    = cnt_q;
    acc_nx   = acc_q + (mb_q[0] ? ma_q : '0);

    if (flags_clr_i) flags_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (opcode_i == OP_MUL) begin
            ma_d    = {{WIDTH{1'b0}}, operand_a_i};
            mb_d    = operand_b_i;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = S_MUL;
          end else begin
            valid_d = 1'b1;
            if (opcode_i != OP_CMP) result_d = sc_res;
            flags_d = {sc_res[WIDTH-1], sc_res == '0,
                       sc_c, sc_v};
          end
        end
      end
      S_MUL: begin
        acc_d = acc_nx;
        ma_d  = ma_q << 1;
        mb_d  = mb_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d  = S_IDLE;
          valid_d  = 1'b1;
          result_d = acc_nx[WIDTH-1:0];
          flags_d  = {acc_nx[WIDTH-1],
                      acc_nx[WIDTH-1:0] == '0,
                      acc_nx[2*WIDTH-1:WIDTH] != '0,
                      1'b0};
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      valid_q  <= 1'b0;
      acc_q    <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: transaction-level model plus
// hand-computed expectations from the test plan.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         valid_i;
  logic         ready_o;
  logic         flags_clr;
  logic [W-1:0] result_o;
  logic         valid_o;
  logic [3:0]   flags_o;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .operand_a_i (a),
    .operand_b_i (b),
    .opcode_i    (op),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .flags_clr_i (flags_clr),
    .result_o    (result_o),
    .valid_o     (valid_o),
    .flags_o     (flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act,
                     input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference ALU in plain integer arithmetic (WIDTH = 8).
  function automatic void model_op(
    input int o, input int x, input int y, input int f,
    output int r, output int nf, output bit upd);
    int sx, sy, sm, sh, c, v, res, ci;
    sx  = (x > 127) ? x - 256 : x;
    sy  = (y > 127) ? y - 256 : y;
    sh  = y & 7;
    ci  = (f >> 1) & 1;
    c   = ci;
    v   = 0;
    res = 0;
    upd = 1;
    case (o)
      0: res = x & y;
      1: res = ~(x & y) & 255;
      2: res = x | y;
      3: res = ~(x | y) & 255;
      4: res = x ^ y;
      5: res = ~(x ^ y) & 255;
      6: begin
        sm = x + y; res = sm & 255; c = (sm >> 8) & 1;
        v = int'((sx + sy) > 127 || (sx + sy) < -128);
      end
      7, 14: begin
        sm = x + (255 - y) + 1; res = sm & 255;
        c = (sm >> 8) & 1;
        v = int'((sx - sy) > 127 || (sx - sy) < -128);
        if (o == 14) upd = 0;
      end
      8: begin
        sm = x + y + ci; res = sm & 255; c = (sm >> 8) & 1;
        v = int'((sx + sy + ci) > 127 || (sx + sy + ci) < -128);
      end
      9: begin
        sm = x + (255 - y) + ci; res = sm & 255;
        c = (sm >> 8) & 1;
        v = int'((sx - sy - 1 + ci) > 127
              || (sx - sy - 1 + ci) < -128);
      end
      10: begin
        res = (x << sh) & 255;
        if (sh != 0) c = (x >> (8 - sh)) & 1;
      end
      11: begin
        res = x >> sh;
        if (sh != 0) c = (x >> (sh - 1)) & 1;
      end
      12: begin
        res = (sx >>> sh) & 255;
        if (sh != 0) c = (x >> (sh - 1)) & 1;
      end
      13: begin
        res = ((x << sh) | (x >> (8 - sh))) & 255;
        if (sh != 0) c = res & 1;
      end
      default: begin
        sm = x * y; res = sm & 255; c = int'(sm > 255);
      end
    endcase
    r  = res;
    nf = (((res >> 7) & 1) << 3) | (int'(res == 0) << 2)
       | (c << 1) | v;
  endfunction

  int m_res, m_flags, m_busy, m_pres, m_pflags;
  int m_old, m_r, m_f;
  bit m_valid, m_acc, m_upd;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_res = 0; m_flags = 0; m_valid = 0; m_busy = 0;
    end else begin
      m_acc   = valid_i && (m_busy == 0);
      m_old   = m_flags;
      m_valid = 0;
      if (flags_clr) m_flags = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1; m_res = m_pres; m_flags = m_pflags;
        end
      end else if (m_acc) begin
        model_op(int'(op), int'(a), int'(b), m_old,
                 m_r, m_f, m_upd);
        if (op == 4'd15) begin
          m_busy = W; m_pres = m_r; m_pflags = m_f;
        end else begin
          m_valid = 1;
          if (m_upd) m_res = m_r;
          m_flags = m_f;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_ready", int'(ready_o), int'(m_busy == 0));
      chk("m_valid", int'(valid_o), int'(m_valid));
      chk("m_result", int'(result_o), m_res);
      chk("m_flags", int'(flags_o), m_flags);
    end
  end

  task automatic issue(input int o, input int x, input int y);
    op = 4'(o); a = 8'(x); b = 8'(y); valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic done(input string name, input int r,
                      input int f);
    @(negedge clk);
    chk({name, "_valid"}, int'(valid_o), 1);
    chk({name, "_res"}, int'(result_o), r);
    chk({name, "_flags"}, int'(flags_o), f);
    chk({name, "_ready"}, int'(ready_o), 1);
  endtask

  task automatic mul_wait(input string name);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk({name, "_busy"}, int'(ready_o), 0);
      chk({name, "_novalid"}, int'(valid_o), 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; a = '0; b = '0; op = '0;
    valid_i = 1'b0; flags_clr = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_res", int'(result_o), 0);
    chk("rst_flags", int'(flags_o), 0);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_ready", int'(ready_o), 1);
    rst_n = 1'b1;

    issue(6, 8'h7F, 8'h01);   done("add_ovf", 8'h80, 4'b1001);
    issue(6, 8'hFF, 8'h01);   done("add_cry", 8'h00, 4'b0110);
    issue(8, 8'h00, 8'h00);   done("adc", 8'h01, 4'b0000);
    issue(9, 8'h10, 8'h01);   done("sbc", 8'h0E, 4'b0010);
    issue(14, 8'h05, 8'h05);  done("cmp", 8'h0E, 4'b0110);

    flags_clr = 1'b1;
    @(posedge clk); #1;
    flags_clr = 1'b0;
    @(negedge clk);
    chk("clr_flags", int'(flags_o), 0);
    chk("clr_valid", int'(valid_o), 0);

    issue(11, 8'h81, 1);      done("shr", 8'h40, 4'b0010);
    issue(12, 8'h80, 3);      done("sar", 8'hF0, 4'b1000);
    issue(13, 8'h81, 1);      done("rol", 8'h03, 4'b0010);
    issue(10, 8'h55, 0);      done("shl0", 8'h55, 4'b0010);
    issue(7, 8'h00, 8'h01);   done("sub_brw", 8'hFF, 4'b1000);
    for (int o = 0; o < 6; o++) begin
      issue(o, 8'hCA, 8'h5C);
      @(negedge clk);
    end
    issue(10, 8'h81, 1);      done("shl1", 8'h02, 4'b0010);

    issue(15, 8'h0D, 8'h0B);
    op = 4'd6; a = 8'h03; b = 8'h04; valid_i = 1'b1;
    mul_wait("mul1");
    done("mul1", 8'h8F, 4'b1000);
    @(posedge clk); #1;
    valid_i = 1'b0;
    done("held_add", 8'h07, 4'b0000);

    issue(15, 8'h10, 8'h10);
    mul_wait("mul2");
    done("mul2", 8'h00, 4'b0110);

    issue(15, 8'h10, 8'h10);
    for (int i = 0; i < 3; i++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_res", int'(result_o), 0);
    chk("abort_flags", int'(flags_o), 0);
    chk("abort_valid", int'(valid_o), 0);
    chk("abort_ready", int'(ready_o), 1);
    for (int i = 0; i < 2 * W; i++) begin
      @(negedge clk);
      chk("abort_novalid", int'(valid_o), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the team's 8-bit combinational ALU: WIDTH-bit datapath, 16 opcodes, and a persistent N/Z/C/V flag register for multi-word ADC/SBC chains.
- Single-cycle ops are registered with a one-cycle result latency; MUL is an iterative shift-add unit taking WIDTH cycles.
- Sits between the register file and writeback, with a valid/ready handshake on the issue side.

Parameters:
- WIDTH, 8: datapath width; power of two, at least 4.
- SHW, $clog2(WIDTH): shift-amount width, taken from operand_b_i[SHW-1:0]; derived, do not override.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- operand_a_i  input  WIDTH  operand A.
- operand_b_i  input  WIDTH  operand B, or the shift amount for shift/rotate ops.
- opcode_i  input  4  operation select.
- valid_i  input  1  issue request.
- ready_o  output  1  unit can accept an op this cycle.
- flags_clr_i  input  1  synchronous clear of flags_o.
- result_o  output  WIDTH  last completed result, held until the next completion.
- valid_o  output  1  one-cycle completion pulse.
- flags_o  output  4  {N,Z,C,V}.

Behaviour:
- Reset: while rst_n_i=0 at a clock edge, result_o=0, flags_o=0, valid_o=0, ready_o=1, FSM=IDLE. Reset applied mid-MUL aborts the operation with no valid_o.
- Accept: an op is accepted when valid_i & ready_o at a rising edge. Operands and opcode are sampled only at accept. valid_i while ready_o=0 is ignored; the issuer must hold it.
- FSM: IDLE (ready_o=1) and MUL (ready_o=0).
  - Single-cycle op accepted in IDLE: result and flags registered; valid_o=1 in the next cycle; FSM stays IDLE.
  - Back-to-back single-cycle ops give throughput of 1 per cycle.
  - MUL accepted in IDLE: latch A, B, acc=0, cnt=0, go to MUL.
  - Each MUL cycle: if B[0], acc+=A. Then A<<=1, B>>=1, cnt++.
  - After the WIDTH-th iteration: result_o=acc[WIDTH-1:0], valid_o=1, ready_o=1 in that same cycle, FSM back to IDLE.
  - MUL accepted at edge N gives valid_o high in the cycle after edge N+WIDTH.
  - An op can be accepted in the valid_o cycle.
- Opcodes:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 ADD (a+b), 7 SUB (a+~b+1).
  - 8 ADC (a+b+C), 9 SBC (a+~b+C).
  - 10 SHL, 11 SHR logical, 12 SAR, 13 ROL, each by b[SHW-1:0].
  - 14 CMP: SUB flags only; result_o unchanged, valid_o still pulses.
  - 15 MUL: low WIDTH bits of the unsigned product.
- Arithmetic is computed at WIDTH+1 bits; C is the carry-out. For SUB/SBC/CMP, C=1 means no borrow (a>=b unsigned for SUB).
- V is signed overflow for ADD/ADC/SUB/SBC/CMP.
- Flags:
  - N = result MSB and Z = (result==0) for every op except CMP, which sets N/Z from the difference.
  - Logic ops: C unchanged, V=0.
  - Shifts/rotate: C = last bit shifted out (ROL: new LSB); V=0. Shift amount 0: result=a, C unchanged.
  - MUL: C = (high half of product != 0), V=0.
- flags_clr_i: clears flags at the edge. If a completion updates flags in the same cycle, the completion wins.
- Flags and result_o change only at completion. Nothing changes while MUL is busy except internal state.

Test Plan:
- WIDTH=8, ADD 0x7F,0x01 -> next cycle valid_o=1, result_o=0x80, flags N=1 Z=0 C=0 V=1; ready_o stays 1.
- ADD 0xFF,0x01 -> 0x00, Z=1 C=1. Then back-to-back ADC 0x00,0x00 -> 0x01, C=0. Then SBC 0x10,0x01 with C=0 -> 0x0E, C=1.
- CMP 0x05,0x05 -> valid_o=1, result_o keeps previous value, Z=1 C=1 N=0 V=0. Then flags_clr_i=1 with no issue -> flags_o=0.
- SHR 0x81 by 1 -> 0x40, C=1. SAR 0x80 by 3 -> 0xF0, C=0, N=1. ROL 0x81 by 1 -> 0x03, C=1. SHL 0x55 by 0 -> 0x55, C unchanged.
- MUL 0x0D,0x0B -> ready_o=0 for 8 cycles; valid_i with opcode ADD held during busy is not accepted. Then valid_o=1 with result_o=0x8F, C=0. The held ADD is accepted in that same cycle.
- MUL 0x10,0x10 -> 0x00, Z=1, C=1. Repeat with rst_n_i=0 at cycle 4 of MUL -> all outputs 0, ready_o=1, no valid_o ever pulses for the aborted op.
